// File: rtl/lpf_pkg.sv
// Shared types and helpers for the streaming LPF integrator.
package lpf_pkg;

  typedef enum logic {
    LPF_MODE_MOVING = 1'b0,
    LPF_MODE_DUMP   = 1'b1
  } lpf_mode_e;

  function automatic int sum_width(input int data_width, input int window);
    return data_width + $clog2(window);
  endfunction

endpackage

// File: rtl/lpf_delay_line.sv
// Circular sample buffer for the moving-sum path; oldest reads zero until WINDOW samples are held.
module lpf_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] oldest,
  output logic                         full,
  output logic                         fill_last
);

  localparam int PW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int CW = $clog2(WINDOW + 1);

  logic signed [DATA_WIDTH-1:0] mem [WINDOW];
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] fill;
  logic [PW-1:0] wr_idx;
  logic [CW-1:0] fill_base;

  // A flushing write becomes the first sample of a fresh window.
  always_comb begin
    wr_idx    = flush ? '0 : wr_ptr;
    fill_base = flush ? '0 : fill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
      for (int unsigned i = 0; i < WINDOW; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
      wr_ptr      <= (wr_idx == PW'(WINDOW - 1)) ? '0 : wr_idx + 1'b1;
      fill        <= (fill_base == CW'(WINDOW)) ? fill_base : fill_base + 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      fill   <= '0;
    end
  end

  always_comb begin
    full      = (fill == CW'(WINDOW));
    fill_last = (fill >= CW'(WINDOW - 1));
    oldest    = full ? mem[wr_ptr] : '0;
  end

endmodule

// File: rtl/lpf_stream_integrator.sv
// Streaming boxcar / integrate-and-dump LPF. Define LPF_AVG_EN to emit the
// round-half-up window average instead of the full-precision sum.
module lpf_stream_integrator
  import lpf_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int WINDOW     = 8,
  localparam int SUM_WIDTH  = sum_width(DATA_WIDTH, WINDOW)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                        mode_dump,
  output logic                        out_valid,
  output logic signed [SUM_WIDTH-1:0] out_data,
  output logic                        primed
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int XW = SUM_WIDTH - DATA_WIDTH;

  if (WINDOW < 2) begin : g_window_chk
    $error("lpf_stream_integrator: WINDOW must be >= 2");
  end

`ifdef LPF_AVG_EN
  localparam int L = $clog2(WINDOW);
  localparam logic signed [SUM_WIDTH-1:0] HALF = SUM_WIDTH'(1 << (L - 1));
  if ((1 << L) != WINDOW) begin : g_pow2_chk
    $error("lpf_stream_integrator: LPF_AVG_EN requires a power-of-two WINDOW");
  end
`endif

  lpf_mode_e mode_q;
  lpf_mode_e mode_in;
  logic signed [SUM_WIDTH-1:0] sum, acc;
  logic [CW-1:0] dump_cnt;

  logic flush;
  logic signed [DATA_WIDTH-1:0] dl_oldest;
  logic dl_full, dl_fill_last;
  logic signed [SUM_WIDTH-1:0] in_ext, old_ext, sum_base, acc_base, sum_nxt, acc_nxt;
  logic signed [SUM_WIDTH-1:0] res_sum, result;
  logic [CW-1:0] cnt_base;
  logic dump_fire, mov_fire;

  lpf_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .WINDOW     (WINDOW)
  ) u_delay_line (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (in_valid && (mode_in == LPF_MODE_MOVING)),
    .wr_data   (in_data),
    .oldest    (dl_oldest),
    .full      (dl_full),
    .fill_last (dl_fill_last)
  );

  // Flushed state is substituted before the update so the switching sample counts as sample 1.
  always_comb begin
    mode_in   = lpf_mode_e'(mode_dump);
    flush     = in_valid && (mode_in != mode_q);
    in_ext    = {{XW{in_data[DATA_WIDTH-1]}}, in_data};
    old_ext   = flush ? '0 : {{XW{dl_oldest[DATA_WIDTH-1]}}, dl_oldest};
    sum_base  = flush ? '0 : sum;
    acc_base  = flush ? '0 : acc;
    cnt_base  = flush ? '0 : dump_cnt;
    sum_nxt   = sum_base + in_ext - old_ext;
    acc_nxt   = acc_base + in_ext;
    dump_fire = (cnt_base == CW'(WINDOW - 1));
    mov_fire  = !flush && dl_fill_last;
    res_sum   = (mode_in == LPF_MODE_DUMP) ? acc_nxt : sum_nxt;
`ifdef LPF_AVG_EN
    result    = (res_sum + HALF) >>> L;
`else
    result    = res_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= LPF_MODE_MOVING;
      sum       <= '0;
      acc       <= '0;
      dump_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        mode_q <= mode_in;
        if (mode_in == LPF_MODE_DUMP) begin
          sum <= sum_base;
          if (dump_fire) begin
            acc       <= '0;
            dump_cnt  <= '0;
            out_valid <= 1'b1;
            out_data  <= result;
          end else begin
            acc      <= acc_nxt;
            dump_cnt <= cnt_base + 1'b1;
          end
        end else begin
          acc      <= acc_base;
          dump_cnt <= cnt_base;
          sum      <= sum_nxt;
          if (mov_fire) begin
            out_valid <= 1'b1;
            out_data  <= result;
          end
        end
      end
    end
  end

  // In dump mode primed is a strobe coincident with each dump.
  assign primed = (mode_q == LPF_MODE_MOVING) ? dl_full : out_valid;

endmodule

// File: tb/tb_lpf_stream_integrator.sv
// Scoreboard bench for lpf_stream_integrator (DATA_WIDTH=5, WINDOW=4); honours LPF_AVG_EN.
module tb_lpf_stream_integrator;

  localparam int DW = 5;
  localparam int WIN = 4;
  localparam int SW = 7;
  localparam bit MV = 1'b0;
  localparam bit DP = 1'b1;

  logic clk = 1'b0;
  logic rst, in_valid, mode_dump;
  logic signed [DW-1:0] in_data;
  logic out_valid, primed;
  logic signed [SW-1:0] out_data;

  int n_tests = 0;
  int n_fail = 0;
  logic signed [SW-1:0] exp_q[$];

  always #5 clk = ~clk;

  lpf_stream_integrator #(
    .DATA_WIDTH (DW),
    .WINDOW     (WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mode_dump (mode_dump),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed)
  );

  function automatic logic signed [SW-1:0] expv(input int s);
`ifdef LPF_AVG_EN
    return SW'((s + 2) >>> 2);
`else
    return SW'(s);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input bit m, input int d, input bit push, input int s);
    in_valid  = 1'b1;
    mode_dump = m;
    in_data   = DW'(d);
    if (push) exp_q.push_back(expv(s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic signed [SW-1:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got out_data %0d with no expected result", out_data);
        end else begin
          e = exp_q.pop_front();
          check("strobe_data", int'(out_data), int'(e));
          check("strobe_primed", int'(primed), 1);
        end
      end
    end
  end

  initial begin
    int t3_sums[4];
    t3_sums = '{-33, -2, 29, 60};
    rst = 1'b1; in_valid = 1'b0; mode_dump = MV; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_primed", int'(primed), 0);
    rst = 1'b0;

    // 1: moving-mode warm-up then sliding sums
    send(MV, 1, 0, 0);
    send(MV, 2, 0, 0);
    send(MV, 3, 0, 0);
    check("t1_primed_warm", int'(primed), 0);
    send(MV, 4, 1, 10);
    check("t1_primed", int'(primed), 1);
    send(MV, 5, 1, 14);
    send(MV, 6, 1, 18);
    check("t1_primed_hold", int'(primed), 1);

    // 2: integrate-and-dump, two windows
    send(DP, 1, 0, 0);
    check("t2_primed_flush", int'(primed), 0);
    send(DP, 2, 0, 0);
    send(DP, 3, 0, 0);
    send(DP, 4, 1, 10);
    check("t2_primed_pulse", int'(primed), 1);
    send(DP, 5, 0, 0);
    check("t2_primed_drop", int'(primed), 0);
    send(DP, 6, 0, 0);
    send(DP, 7, 0, 0);
    send(DP, 8, 1, 26);

    // 3: extremes in moving mode
    for (int i = 0; i < 4; i++) send(MV, -16, (i == 3), -64);
    for (int i = 0; i < 4; i++) send(MV, 15, 1'b1, t3_sums[i]);

    // 4: in_valid gaps
    pulse_rst();
    send(MV, 1, 0, 0);
    idle();
    check("t4_gap1_valid", int'(out_valid), 0);
    send(MV, 2, 0, 0);
    idle();
    check("t4_gap2_valid", int'(out_valid), 0);
    send(MV, 3, 0, 0);
    idle();
    check("t4_gap3_valid", int'(out_valid), 0);
    send(MV, 4, 1, 10);

    // 5: reset mid-stream discards the window
    send(MV, 1, 1, 10);
    send(MV, 1, 1, 9);
    pulse_rst();
    check("t5_rst_out_data", int'(out_data), 0);
    check("t5_rst_primed", int'(primed), 0);
    check("t5_rst_out_valid", int'(out_valid), 0);
    send(MV, 1, 0, 0);
    send(MV, 1, 0, 0);
    send(MV, 1, 0, 0);
    send(MV, 1, 1, 4);

    // 6: moving -> dump switch, with the mode change first seen on an idle cycle
    pulse_rst();
    for (int i = 0; i < 4; i++) send(MV, 1, (i == 3), 4);
    mode_dump = DP;
    idle();
    check("t6_idle_switch_valid", int'(out_valid), 0);
    check("t6_idle_switch_primed", int'(primed), 1);
    send(DP, 2, 0, 0);
    check("t6_primed_flush", int'(primed), 0);
    send(DP, 2, 0, 0);
    send(DP, 2, 0, 0);
    send(DP, 2, 1, 8);

    repeat (3) idle();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
